// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter fed by a first-word-fall-through FIFO.
// Pops one byte per frame and shifts it out LSB first, using a 16x baud tick
// for bit timing. The stop-bit length is set by SB_TICK.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // The tick counter must reach both 15 (data bits) and SB_TICK-1 (stop bits).
    localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [SW-1:0]     s_r, s_s;
    logic [NW-1:0]     n_r, n_s;
    logic [DBIT-1:0]   b_r, b_s;
    logic              tx_r, tx_s;
    logic              done_r, done_s;
    logic              busy_r;
    logic              rd_s;

    // Next-state, counter and shift-register decode; the line value follows the next state.
    always_comb begin
        state_s = state_r;
        s_s     = s_r;
        n_s     = n_r;
        b_s     = b_r;
        done_s  = 1'b0;
        // Holding off the pop during the done pulse keeps tx_done_tick and the
        // next frame's rd in separate cycles.
        rd_s    = rst && (state_r == IDLE) && !empty && !done_r;

        case (state_r)
            IDLE: begin
                if (rd_s) begin
                    b_s     = r_data;
                    s_s     = {SW{1'b0}};
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_r == S_BIT_LAST) begin
                        s_s     = {SW{1'b0}};
                        n_s     = {NW{1'b0}};
                        state_s = DATA;
                    end else begin
                        s_s = s_r + SW'(1);
                    end
                end else begin
                    s_s = s_r;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_r == S_BIT_LAST) begin
                        s_s = {SW{1'b0}};
                        b_s = b_r >> 1;
                        if (n_r == N_LAST) begin
                            state_s = STOP;
                        end else begin
                            n_s = n_r + NW'(1);
                        end
                    end else begin
                        s_s = s_r + SW'(1);
                    end
                end else begin
                    s_s = s_r;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_r == S_STOP_LAST) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        s_s = s_r + SW'(1);
                    end
                end else begin
                    s_s = s_r;
                end
            end
            default: begin
                state_s = IDLE;
                s_s     = {SW{1'b0}};
                n_s     = {NW{1'b0}};
                b_s     = {DBIT{1'b0}};
            end
        endcase

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = b_s[0];
            STOP:    tx_s = 1'b1;
            IDLE:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State, counters, shift register and registered outputs; reset abandons any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            s_r     <= {SW{1'b0}};
            n_r     <= {NW{1'b0}};
            b_r     <= {DBIT{1'b0}};
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            s_r     <= s_s;
            n_r     <= n_s;
            b_r     <= b_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    assign rd           = rd_s;
    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed table-driven bench for uart_tx with a queue-based FIFO.
module tb_uart_tx;

    localparam int LOGN = 4096;

    typedef struct {
        logic [7:0] data;
        int         dv;
        int         sb;
        logic [7:0] exp_byte;
        int         exp_lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       sel = 1'b0;

    logic empty_a, rd_a, tx_a, busy_a, done_a;
    logic empty_b, rd_b, tx_b, busy_b, done_b;
    logic cur_rd, cur_tx, cur_busy, cur_done;

    logic [7:0] q[$];
    logic l_tx   [0:LOGN-1];
    logic l_rd   [0:LOGN-1];
    logic l_busy [0:LOGN-1];
    logic l_done [0:LOGN-1];

    int ci = 0;
    int dv_cur = 1;
    int tick_cnt = 0;
    int checks = 0;
    int passed = 0;

    assign empty_a  = sel ? 1'b1 : fifo_empty;
    assign empty_b  = sel ? fifo_empty : 1'b1;
    assign cur_rd   = sel ? rd_b : rd_a;
    assign cur_tx   = sel ? tx_b : tx_a;
    assign cur_busy = sel ? busy_b : busy_a;
    assign cur_done = sel ? done_b : done_a;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .empty(empty_a), .r_data(r_data),
        .rd(rd_a), .tx(tx_a), .tx_busy(busy_a), .tx_done_tick(done_a)
    );

    uart_tx #(.DBIT(8), .SB_TICK(32)) dut2 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .empty(empty_b), .r_data(r_data),
        .rd(rd_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    task automatic push(input logic [7:0] v);
        q.push_back(v);
        fifo_empty = 1'b0;
        r_data     = q[0];
    endtask

    // One clock cycle: log outputs mid-cycle, pop on rd, then drive the next tick.
    task automatic cyc();
        logic       rd_seen;
        logic [7:0] tmp;
        @(negedge clk);
        if (ci < LOGN) begin
            l_tx[ci]   = cur_tx;
            l_rd[ci]   = cur_rd;
            l_busy[ci] = cur_busy;
            l_done[ci] = cur_done;
        end
        rd_seen = cur_rd;
        @(posedge clk);
        #1;
        if (rd_seen && q.size() > 0) begin
            tmp = q.pop_front();
            fifo_empty = (q.size() == 0);
            r_data     = fifo_empty ? 8'h00 : q[0];
        end
        if (rd_seen) tick_cnt = 0;
        tick_cnt++;
        s_tick = ((tick_cnt % dv_cur) == 0);
        ci++;
    endtask

    function automatic logic [7:0] decode(input int p, input int dv);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = l_tx[p + 1 + dv * (16 * (k + 1) + 8)];
        return b;
    endfunction

    // Counts cycles whose line or busy level differs from the ideal frame shape.
    function automatic int shape_errs(input int p, input int dv, input logic [7:0] data, input int sb);
        int   total, errs, j;
        logic e_tx, e_busy;
        total = (144 + sb) * dv;
        errs  = 0;
        if (l_tx[p] !== 1'b1 || l_busy[p] !== 1'b0) errs++;
        for (int t = 0; t <= total; t++) begin
            j = t / (16 * dv);
            if (t == total) begin
                e_tx = 1'b1; e_busy = 1'b0;
            end else if (j == 0) begin
                e_tx = 1'b0; e_busy = 1'b1;
            end else if (j <= 8) begin
                e_tx = data[j - 1]; e_busy = 1'b1;
            end else begin
                e_tx = 1'b1; e_busy = 1'b1;
            end
            if (l_tx[p + 1 + t] !== e_tx || l_busy[p + 1 + t] !== e_busy) errs++;
        end
        return errs;
    endfunction

    task automatic run_frame(input string nm, input logic [7:0] data, input logic [7:0] exp_byte,
                             input int dv, input int sb, input int exp_lat);
        int p, d, guard, nrd, ndone, bsy;
        p = -1; d = -1; guard = 0; dv_cur = dv; ci = 0;
        while ((d < 0 || ci < d + 4) && guard < 3000) begin
            cyc();
            if (p < 0 && l_rd[ci - 1]) p = ci - 1;
            if (d < 0 && l_done[ci - 1]) d = ci - 1;
            guard++;
        end
        if (p < 0 || d < 0) begin
            check({nm, "_timeout"}, 0, 1);
            return;
        end
        nrd = 0; ndone = 0; bsy = 0;
        for (int i = 0; i < ci; i++) begin
            nrd   += int'(l_rd[i]);
            ndone += int'(l_done[i]);
            if (l_rd[i] && l_busy[i]) bsy++;
        end
        check({nm, "_rd_count"}, nrd, 1);
        check({nm, "_done_count"}, ndone, 1);
        check({nm, "_done_latency"}, d - (p + 1), exp_lat);
        check({nm, "_decoded"}, int'(decode(p, dv)), int'(exp_byte));
        check({nm, "_line_shape_errs"}, shape_errs(p, dv, data, sb), 0);
        check({nm, "_rd_while_busy"}, bsy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   bad, guard, nrd, ndone;
        int   rdi[4];
        int   dni[4];
        int   p, target;

        vecs[0] = '{8'hA5, 1, 16, 8'hA5, 160};
        vecs[1] = '{8'h3C, 4, 16, 8'h3C, 640};
        vecs[2] = '{8'h55, 2, 16, 8'h55, 320};
        vecs[3] = '{8'h00, 1, 16, 8'h00, 160};
        vecs[4] = '{8'hFF, 1, 32, 8'hFF, 176};

        // Reset takes effect before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst_async_tx", int'(tx_a), 1);
        check("rst_async_rd", int'(rd_a), 0);
        check("rst_async_busy", int'(busy_a), 0);
        check("rst_async_done", int'(done_a), 0);
        repeat (3) cyc();
        rst = 1'b1;

        // Idle with an empty FIFO: nothing moves despite ticks.
        ci = 0; dv_cur = 1;
        repeat (200) cyc();
        bad = 0;
        for (int i = 0; i < 200; i++)
            if (l_tx[i] !== 1'b1 || l_rd[i] !== 1'b0 || l_busy[i] !== 1'b0 || l_done[i] !== 1'b0) bad++;
        check("idle_hold_bad_cycles", bad, 0);

        // Table of single frames.
        for (int i = 0; i < 5; i++) begin
            sel = (vecs[i].sb == 32);
            push(vecs[i].data);
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_byte,
                      vecs[i].dv, vecs[i].sb, vecs[i].exp_lat);
        end
        sel = 1'b0;

        // Back-to-back frames 0x01 then 0x80.
        push(8'h01); push(8'h80);
        ci = 0; dv_cur = 1; guard = 0; nrd = 0; ndone = 0;
        while ((ndone < 2 || ci < dni[1] + 4) && guard < 1000) begin
            cyc();
            if (l_rd[ci - 1]) begin
                if (nrd < 4) rdi[nrd] = ci - 1;
                nrd++;
            end
            if (l_done[ci - 1]) begin
                if (ndone < 4) dni[ndone] = ci - 1;
                ndone++;
            end
            guard++;
        end
        if (nrd >= 2 && ndone >= 2) begin
            check("b2b_rd_count", nrd, 2);
            check("b2b_done_count", ndone, 2);
            check("b2b_rd_after_done", rdi[1] - dni[0], 1);
            check("b2b_byte0", int'(decode(rdi[0], 1)), 8'h01);
            check("b2b_byte1", int'(decode(rdi[1], 1)), 8'h80);
            check("b2b_gap_high", int'(l_tx[rdi[1]]), 1);
            check("b2b_second_start", int'(l_tx[rdi[1] + 1]), 0);
            check("b2b_second_latency", dni[1] - (rdi[1] + 1), 160);
            check("b2b_fifo_empty", int'(fifo_empty), 1);
        end else begin
            check("b2b_timeout", 0, 1);
        end

        // Reset during data bit 3 of 0xA5, then a clean frame of 0x5A.
        push(8'hA5);
        ci = 0; dv_cur = 1; guard = 0; p = -1; target = -1;
        while (guard < 400) begin
            cyc();
            if (p < 0 && l_rd[ci - 1]) begin
                p = ci - 1;
                target = p + 1 + 16 * 4 + 5;
            end
            guard++;
            if (p >= 0 && ci - 1 == target) break;
        end
        if (p < 0 || ci - 1 != target) begin
            check("rstmid_timeout", 0, 1);
        end else begin
            check("rstmid_bit3_low", int'(l_tx[target]), 0);
            #2 rst = 1'b0;
            #1;
            check("rstmid_tx_now", int'(tx_a), 1);
            check("rstmid_busy_now", int'(busy_a), 0);
            check("rstmid_done_now", int'(done_a), 0);
            push(8'h5A);
            #1;
            check("rstmid_rd_forced", int'(rd_a), 0);
            repeat (2) cyc();
            rst = 1'b1;
            run_frame("rst_recover", 8'h5A, 8'h5A, 1, 16, 160);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
